// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter and its ack watchdog.
package wb_arb_pkg;

  localparam int WDOG_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/wb_ack_watchdog.sv
// Counts un-acked cycles of a Wishbone transfer and flags expiry at TIMEOUT.
module wb_ack_watchdog
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic ack,
  input  logic clr,
  output logic expire
);

  localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT);

  logic [WDOG_W-1:0] wdog_q;
  logic [WDOG_W-1:0] wdog_d;

  // Saturates at LIMIT; an ack on the limit cycle clears instead of expiring.
  always_comb begin
    wdog_d = wdog_q;
    if (clr || ack) begin
      wdog_d = '0;
    end else if (en && (wdog_q != LIMIT)) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end

  assign expire = (wdog_q == LIMIT) && !ack;

endmodule

// File: rtl/wb_arbiter_2m.sv
// Round-robin arbiter sharing one Wishbone slave between two masters,
// holding each grant for the whole bus cycle, with an ack timeout.
module wb_arbiter_2m
  import wb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_cycle,
  input  logic                  m0_write,
  input  logic [ADDR_WIDTH-1:0] m0_address,
  input  logic [DATA_WIDTH-1:0] m0_writedata,
  output logic [DATA_WIDTH-1:0] m0_readdata,
  output logic                  m0_ack,
  output logic                  m0_err,
  input  logic                  m1_cycle,
  input  logic                  m1_write,
  input  logic [ADDR_WIDTH-1:0] m1_address,
  input  logic [DATA_WIDTH-1:0] m1_writedata,
  output logic [DATA_WIDTH-1:0] m1_readdata,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic                  wbs_cycle,
  output logic                  wbs_write,
  output logic [ADDR_WIDTH-1:0] wbs_address,
  output logic [DATA_WIDTH-1:0] wbs_writedata,
  input  logic [DATA_WIDTH-1:0] wbs_readdata,
  input  logic                  wbs_ack,
  output logic [1:0]            grant
);

  arb_state_e state_q;
  arb_state_e state_d;
  logic       last_q;
  logic       last_d;
  logic       leave;
  logic       expire;
  logic       own_cycle;
  logic       err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Every release passes through IDLE so the slave always sees a cycle boundary.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    leave   = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (m0_cycle && m1_cycle) begin
          state_d = last_q ? ARB_GNT0 : ARB_GNT1;
        end else if (m0_cycle) begin
          state_d = ARB_GNT0;
        end else if (m1_cycle) begin
          state_d = ARB_GNT1;
        end
      end
      ARB_GNT0: begin
        if (!m0_cycle || expire) begin
          state_d = ARB_IDLE;
          last_d  = 1'b0;
          leave   = 1'b1;
        end
      end
      ARB_GNT1: begin
        if (!m1_cycle || expire) begin
          state_d = ARB_IDLE;
          last_d  = 1'b1;
          leave   = 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    own_cycle     = 1'b0;
    wbs_write     = 1'b0;
    wbs_address   = '0;
    wbs_writedata = '0;
    case (state_q)
      ARB_GNT0: begin
        own_cycle     = m0_cycle;
        wbs_write     = m0_write;
        wbs_address   = m0_address;
        wbs_writedata = m0_writedata;
      end
      ARB_GNT1: begin
        own_cycle     = m1_cycle;
        wbs_write     = m1_write;
        wbs_address   = m1_address;
        wbs_writedata = m1_writedata;
      end
      default: ;
    endcase
  end

  wb_ack_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .en     (wbs_cycle),
    .ack    (wbs_ack),
    .clr    (leave),
    .expire (expire)
  );

  // The error cycle drops wbs_cycle so the slave abandons the hung transfer.
  assign wbs_cycle = own_cycle && !expire;
  assign err       = own_cycle && expire;
  assign grant     = {state_q == ARB_GNT1, state_q == ARB_GNT0};

  assign m0_ack      = grant[0] && wbs_ack;
  assign m0_err      = grant[0] && err;
  assign m0_readdata = grant[0] ? wbs_readdata : '0;
  assign m1_ack      = grant[1] && wbs_ack;
  assign m1_err      = grant[1] && err;
  assign m1_readdata = grant[1] ? wbs_readdata : '0;

endmodule

// File: doc/wb_arbiter_2m.md
Name: wb_arbiter_2m

Overview:
- Two-master, one-slave Wishbone arbiter. It shares a single Wishbone slave (e.g. the LED register block) between the ARM bridge (master 0) and an on-FPGA requester (master 1).
- Grants are round-robin. A grant is held for the whole bus cycle.
- A per-transfer ack watchdog stops a hung slave from locking the bus.
- Sits between the bus masters and the slave's wbs_* port, and adds no datapath logic.

Parameters:
- ADDR_WIDTH, 5, address bus width.
- DATA_WIDTH, 16, data bus width.
- TIMEOUT, 15, max cycles a granted transfer waits for slave ack before error; legal range 1..255.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- m0_cycle  in  1  master 0 bus cycle request/in progress
- m0_write  in  1  master 0 write (1) / read (0)
- m0_address  in  ADDR_WIDTH  master 0 address
- m0_writedata  in  DATA_WIDTH  master 0 write data
- m0_readdata  out  DATA_WIDTH  read data to master 0
- m0_ack  out  1  ack to master 0
- m0_err  out  1  timeout error to master 0
- m1_cycle, m1_write, m1_address, m1_writedata, m1_readdata, m1_ack, m1_err: same as m0_*, for master 1
- wbs_cycle  out  1  cycle to slave
- wbs_write  out  1  write to slave
- wbs_address  out  ADDR_WIDTH  address to slave
- wbs_writedata  out  DATA_WIDTH  write data to slave
- wbs_readdata  in  DATA_WIDTH  slave read data
- wbs_ack  in  1  slave ack
- grant  out  2  one-hot current owner (debug/status)

Behaviour:
- State reg: IDLE, GNT0, GNT1; plus last-owner bit `last`, and a watchdog counter wdog of 8 bits.
- Reset (reset=0, async):
  - state=IDLE, last=1 (master 0 wins first tie), wdog=0.
  - All outputs 0: wbs_cycle, wbs_write, wbs_address, wbs_writedata, m*_ack, m*_err, m*_readdata, grant.
- IDLE:
  - Only m0_cycle=1 -> GNT0. Only m1_cycle=1 -> GNT1.
  - Both requesting -> grant the master != last.
  - Transition takes one clock: a request sampled at edge N gives grant and wbs_cycle high from edge N.
- GNTx, slave side:
  - wbs_* = master x signals, muxed combinationally from registered state.
  - The non-owner sees ack=0 and err=0.
- GNTx, read data:
  - m*_readdata = wbs_readdata for the owner; 0 for the non-owner.
  - Read data is valid when m*_ack=1.
- GNTx, ack and watchdog:
  - mx_ack = wbs_ack (combinational, same cycle).
  - wdog increments each cycle wbs_cycle=1 && wbs_ack=0. It clears on wbs_ack=1.
- Leaving GNTx:
  - mx_cycle falls -> IDLE next edge; last=x; wdog=0. The master may keep cycle high for back-to-back transfers; there is no preemption.
  - wdog reaches TIMEOUT -> mx_err=1 for exactly one cycle; that cycle wbs_cycle is forced 0. Then -> IDLE, last=x, wdog=0.
  - wbs_ack arriving in the same cycle wdog==TIMEOUT: the ack wins; no err; wdog clears.
- Back-to-back requests: IDLE always takes ≥1 cycle between owners. wbs_cycle is low for at least one clock on every owner change, so the slave sees a cycle boundary.
- Owner drops cycle mid-transfer with no ack: the transfer is abandoned, -> IDLE; no err.
- Requester changes wbs_* inputs while holding cycle: passed through unchanged; the arbiter does not latch them.
- grant = {state==GNT1, state==GNT0}.
- wdog saturates at TIMEOUT; it never wraps.

Decomposition:
- Package wb_arb_pkg:
  - state encoding constants ARB_IDLE=2'd0, ARB_GNT0=2'd1, ARB_GNT1=2'd2.
  - Watchdog width constant WDOG_W=8.
- Sub-module wb_ack_watchdog:
  - Inputs: clk, reset, en (=wbs_cycle), ack, clr.
  - Output: expire.
  - Parameterised by TIMEOUT.
  - Reused later for other Wishbone bridges.

Test Plan:
- Reset, then m0 writes 16'h0005 to addr 0, slave acks 1 cycle later -> grant=01; wbs_writedata=0005; m0_ack pulse; LED reg reads back 0005 via m0 read.
- m0_cycle and m1_cycle rise in the same cycle after reset -> m0 granted first. After m0 drops cycle, 1 IDLE cycle, then grant=10. Repeat simultaneous request -> m0 granted (alternation holds over 4 rounds).
- m1 holds cycle for 3 back-to-back reads (addr 0,1,2) while m0 requests -> m0 stays ungranted with m0_ack=0 until m1 drops cycle.
- Slave never acks, TIMEOUT=15, m0 requesting -> m0_err=1 on the 16th granted cycle, wbs_cycle=0 that cycle, then IDLE; m1 then granted normally.
- Slave acks exactly on cycle wdog==TIMEOUT -> m0_ack=1, m0_err=0.
- Assert reset mid-grant (GNT1, wdog=7) -> all outputs 0 immediately (async); after release, state IDLE, master 0 wins the next tie.
